// File: rtl/tonegen_mc.sv
// Multi-channel DDS sine generator: NCH phase accumulators share one quarter-wave
// ROM and one multiplier, producing one sample per channel on each frame strobe.
module tonegen_mc #(
    parameter int NCH     = 4,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 18,
    parameter int GAIN_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               frame_strobe,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_ch,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [GAIN_W-1:0]  cfg_gain,
    input  logic               cfg_en,
    input  logic               cfg_clr,
    output logic               smp_valid,
    output logic [3:0]         smp_ch,
    output logic [OUT_W-1:0]   smp_data,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

    localparam int MAG_W  = OUT_W - 1;
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ROM_N  = 2 ** LUT_AW;
    localparam int PROD_W = OUT_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam longint PI_Q30 = 64'sd3373259426;   // pi * 2^30

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LUT, S_MUL, S_OUT} state_e;

    // round((2^(OUT_W-1)-1) * sin(pi/2*(k+0.5)/2^LUT_AW)) via a Q30 Taylor series
    function automatic logic [MAG_W-1:0] lut_entry(input int k);
        longint x, x2, term, sum;
        x    = (PI_Q30 * longint'(2 * k + 1)) >>> (LUT_AW + 2);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return MAG_W'((((longint'(1) << MAG_W) - 1) * sum + (longint'(1) << 29)) >>> 30);
    endfunction

    // NOTE: the ROM is constant logic, so unlike the state flops it has no reset.
    logic [MAG_W-1:0] rom [ROM_N];
    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        assign rom[k] = lut_entry(k);
    end

    state_e              state_q, state_d;
    logic [3:0]          ch_q, ch_d;
    logic [1:0]          quad_q, quad_d;
    logic [LUT_AW-1:0]   addr_q, addr_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic                smp_valid_q, smp_valid_d;
    logic [3:0]          smp_ch_q, smp_ch_d;
    logic [OUT_W-1:0]    smp_data_q, smp_data_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;

    logic [PHASE_W-1:0]  sh_inc_q [NCH], sh_inc_d [NCH];
    logic [GAIN_W-1:0]   sh_gain_q [NCH], sh_gain_d [NCH];
    logic [NCH-1:0]      sh_en_q, sh_en_d;
    logic [NCH-1:0]      clr_pend_q, clr_pend_d;
    logic [PHASE_W-1:0]  inc_q [NCH], inc_d [NCH];
    logic [GAIN_W-1:0]   gain_q [NCH], gain_d [NCH];
    logic [NCH-1:0]      en_q, en_d;
    logic [PHASE_W-1:0]  phase_q [NCH], phase_d [NCH];

    logic [CH_W-1:0]     cidx;
    logic signed [OUT_W-1:0]  smag;
    logic signed [GAIN_W:0]   gsat;
    logic signed [PROD_W-1:0] prod;

    assign cidx = ch_q[CH_W-1:0];
    assign smag = quad_q[1] ? -$signed({1'b0, mag_q}) : $signed({1'b0, mag_q});
    assign gsat = (gain_q[cidx] > UNITY) ? $signed({1'b0, UNITY}) : $signed({1'b0, gain_q[cidx]});
    assign prod = PROD_W'(smag) * PROD_W'(gsat);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can infer a latch.
        state_d      = state_q;
        ch_d         = ch_q;
        quad_d       = quad_q;
        addr_d       = addr_q;
        mag_d        = mag_q;
        smp_valid_d  = 1'b0;
        smp_ch_d     = smp_ch_q;
        smp_data_d   = smp_data_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (frame_strobe & (busy | frame_done_q));
        sh_inc_d     = sh_inc_q;
        sh_gain_d    = sh_gain_q;
        sh_en_d      = sh_en_q;
        clr_pend_d   = clr_pend_q;
        inc_d        = inc_q;
        gain_d       = gain_q;
        en_d         = en_q;
        phase_d      = phase_q;

        case (state_q)
            S_IDLE: begin
                // A strobe coinciding with frame_done counts as arriving while busy
                if (frame_strobe && !frame_done_q) begin
                    inc_d  = sh_inc_q;
                    gain_d = sh_gain_q;
                    en_d   = sh_en_q;
                    for (int i = 0; i < NCH; i++) begin
                        if (clr_pend_q[i]) phase_d[i] = '0;
                    end
                    clr_pend_d = '0;
                    ch_d       = '0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                quad_d  = phase_q[cidx][PHASE_W-1 -: 2];
                addr_d  = phase_q[cidx][PHASE_W-2] ? ~phase_q[cidx][PHASE_W-3 -: LUT_AW]
                                                   :  phase_q[cidx][PHASE_W-3 -: LUT_AW];
                state_d = S_LUT;
            end
            S_LUT: begin
                mag_d   = rom[addr_q];
                state_d = S_MUL;
            end
            S_MUL: begin
                smp_valid_d = 1'b1;
                smp_ch_d    = ch_q;
                smp_data_d  = en_q[cidx] ? OUT_W'(prod >>> (GAIN_W - 1)) : '0;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (en_q[cidx]) phase_d[cidx] = phase_q[cidx] + inc_q[cidx];
                if (ch_q == 4'(NCH - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    state_d = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shadow writes come last so a write in the start cycle survives for the next frame
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == 4'(i)) begin
                sh_inc_d[i]   = cfg_inc;
                sh_gain_d[i]  = cfg_gain;
                sh_en_d[i]    = cfg_en;
                clr_pend_d[i] = cfg_clr;
            end
        end
    end

    // NOTE: sequential state is updated with <= only; = here would race other flops.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            quad_q       <= '0;
            addr_q       <= '0;
            mag_q        <= '0;
            smp_valid_q  <= 1'b0;
            smp_ch_q     <= '0;
            smp_data_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            sh_inc_q     <= '{default: '0};
            sh_gain_q    <= '{default: '0};
            sh_en_q      <= '0;
            clr_pend_q   <= '0;
            inc_q        <= '{default: '0};
            gain_q       <= '{default: '0};
            en_q         <= '0;
            phase_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            quad_q       <= quad_d;
            addr_q       <= addr_d;
            mag_q        <= mag_d;
            smp_valid_q  <= smp_valid_d;
            smp_ch_q     <= smp_ch_d;
            smp_data_q   <= smp_data_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            sh_inc_q     <= sh_inc_d;
            sh_gain_q    <= sh_gain_d;
            sh_en_q      <= sh_en_d;
            clr_pend_q   <= clr_pend_d;
            inc_q        <= inc_d;
            gain_q       <= gain_d;
            en_q         <= en_d;
            phase_q      <= phase_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign smp_valid  = smp_valid_q;
    assign smp_ch     = smp_ch_q;
    assign smp_data   = smp_data_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tonegen_mc.sv
// Directed bench for tonegen_mc: a table of single-channel frames plus
// hand-written sequences for frame timing, overrun, config timing and reset.
module tb_tonegen_mc;

    localparam int NCH       = 4;
    localparam int PHASE_W   = 24;
    localparam int GAIN_W    = 16;
    localparam int OUT_W     = 18;
    localparam int FRAME_CYC = 4 * NCH + 1;
    localparam longint LUT0   = 402;      // lut[0]
    localparam longint LUT255 = 131070;   // lut[255]

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               frame_strobe = 1'b0;
    logic               cfg_we = 1'b0;
    logic [3:0]         cfg_ch = '0;
    logic [PHASE_W-1:0] cfg_inc = '0;
    logic [GAIN_W-1:0]  cfg_gain = '0;
    logic               cfg_en = 1'b0;
    logic               cfg_clr = 1'b0;
    logic               smp_valid;
    logic [3:0]         smp_ch;
    logic [OUT_W-1:0]   smp_data;
    logic               busy;
    logic               frame_done;
    logic               overrun;

    tonegen_mc #(.NCH(NCH), .PHASE_W(PHASE_W), .LUT_AW(8), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .frame_strobe (frame_strobe),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_inc      (cfg_inc),
        .cfg_gain     (cfg_gain),
        .cfg_en       (cfg_en),
        .cfg_clr      (cfg_clr),
        .smp_valid    (smp_valid),
        .smp_ch       (smp_ch),
        .smp_data     (smp_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PHASE_W-1:0] inc;
        logic [GAIN_W-1:0]  gain;
        bit                 en;
        bit                 clr;
        longint             exp0;
    } vec_t;

    vec_t tbl [18];

    longint samp [16];
    int     nvalid, ndone;
    bit     busy_log [32], valid_log [32], done_log [32], ovr_log [32];
    int     ch_log [32];
    longint data_log [32];

    int stb2_cycle = -1;
    int wr_cycle   = -1;
    int rst_cycle  = -1;
    logic [3:0]         wr_ch;
    logic [PHASE_W-1:0] wr_inc;
    logic [GAIN_W-1:0]  wr_gain;
    bit                 wr_en, wr_clr;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input logic [PHASE_W-1:0] inc,
                             input logic [GAIN_W-1:0] gain, input bit en, input bit clr);
        cfg_we   = 1'b1;
        cfg_ch   = 4'(ch);
        cfg_inc  = inc;
        cfg_gain = gain;
        cfg_en   = en;
        cfg_clr  = clr;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Point k is sampled one step after clock edge k-1; the strobe is driven at point 0.
    task automatic run_frame();
        for (int c = 0; c < 16; c++) samp[c] = -999999;
        nvalid = 0;
        ndone  = 0;
        for (int k = 0; k <= FRAME_CYC + 2; k++) begin
            busy_log[k]  = busy;
            valid_log[k] = smp_valid;
            done_log[k]  = frame_done;
            ovr_log[k]   = overrun;
            ch_log[k]    = int'(smp_ch);
            data_log[k]  = longint'($signed(smp_data));
            if (smp_valid) begin
                samp[smp_ch] = longint'($signed(smp_data));
                nvalid++;
            end
            if (frame_done) ndone++;
            frame_strobe = (k == 0) || (k == stb2_cycle);
            reset_n      = (k == rst_cycle) ? 1'b0 : 1'b1;
            cfg_we       = (k == wr_cycle);
            if (k == wr_cycle) begin
                cfg_ch   = wr_ch;
                cfg_inc  = wr_inc;
                cfg_gain = wr_gain;
                cfg_en   = wr_en;
                cfg_clr  = wr_clr;
            end
            tick();
        end
        frame_strobe = 1'b0;
        cfg_we       = 1'b0;
        reset_n      = 1'b1;
        stb2_cycle   = -1;
        wr_cycle     = -1;
        rst_cycle    = -1;
    endtask

    initial begin
        tbl[0]  = '{24'h400000, 16'h8000, 1'b1, 1'b1, LUT0};
        tbl[1]  = '{24'h400000, 16'h8000, 1'b1, 1'b0, LUT255};
        tbl[2]  = '{24'h400000, 16'h8000, 1'b1, 1'b0, -LUT0};
        tbl[3]  = '{24'h400000, 16'h8000, 1'b1, 1'b0, -LUT255};
        tbl[4]  = '{24'h400000, 16'h8000, 1'b1, 1'b0, LUT0};
        tbl[5]  = '{24'h400000, 16'h4000, 1'b1, 1'b0, 65535};
        tbl[6]  = '{24'h400000, 16'hFFFF, 1'b1, 1'b0, -LUT0};
        tbl[7]  = '{24'h400000, 16'h2000, 1'b1, 1'b0, -32768};
        tbl[8]  = '{24'h400000, 16'h0000, 1'b1, 1'b0, 0};
        tbl[9]  = '{24'h000000, 16'h8000, 1'b1, 1'b0, LUT255};
        tbl[10] = '{24'h000000, 16'h8000, 1'b1, 1'b0, LUT255};
        tbl[11] = '{24'h800000, 16'h2000, 1'b1, 1'b0, 32767};
        tbl[12] = '{24'h800000, 16'h2000, 1'b1, 1'b0, -32768};
        tbl[13] = '{24'h400000, 16'h8000, 1'b0, 1'b0, 0};
        tbl[14] = '{24'h400000, 16'h8000, 1'b1, 1'b0, LUT255};
        tbl[15] = '{24'h400000, 16'h8000, 1'b1, 1'b1, LUT0};
        tbl[16] = '{24'h400000, 16'h4000, 1'b1, 1'b0, 65535};
        tbl[17] = '{24'h400000, 16'h2000, 1'b1, 1'b0, -101};

        // Reset held with strobes applied
        reset_n      = 1'b0;
        frame_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d_valid", i), longint'(smp_valid), 0);
            check($sformatf("rst%0d_busy", i), longint'(busy), 0);
            check($sformatf("rst%0d_done", i), longint'(frame_done), 0);
            check($sformatf("rst%0d_overrun", i), longint'(overrun), 0);
            check($sformatf("rst%0d_data", i), longint'(smp_data), 0);
        end
        frame_strobe = 1'b0;
        reset_n      = 1'b1;
        tick();

        // Table: ch0 only, one frame per entry
        for (int i = 0; i < 18; i++) begin
            cfg_write(0, tbl[i].inc, tbl[i].gain, tbl[i].en, tbl[i].clr);
            run_frame();
            check($sformatf("tbl%0d_ch0", i), samp[0], tbl[i].exp0);
        end
        check("tbl_nvalid", longint'(nvalid), NCH);
        check("tbl_ch1_disabled", samp[1], 0);

        // Frame timing with all channels enabled
        cfg_write(0, 24'h0, 16'h8000, 1'b1, 1'b1);
        cfg_write(1, 24'h0, 16'h4000, 1'b1, 1'b1);
        cfg_write(2, 24'h0, 16'h0000, 1'b1, 1'b1);
        cfg_write(3, 24'h0, 16'h8000, 1'b1, 1'b1);
        run_frame();
        for (int k = 0; k <= FRAME_CYC + 2; k++) begin
            check($sformatf("tim_busy@%0d", k), longint'(busy_log[k]), longint'(k >= 1 && k <= 16));
            check($sformatf("tim_valid@%0d", k), longint'(valid_log[k]),
                  longint'(k >= 4 && k <= 16 && (k % 4) == 0));
            check($sformatf("tim_done@%0d", k), longint'(done_log[k]), longint'(k == FRAME_CYC));
            if (k >= 4 && k <= 16 && (k % 4) == 0)
                check($sformatf("tim_ch@%0d", k), longint'(ch_log[k]), longint'(k / 4 - 1));
        end
        check("tim_ch0", samp[0], LUT0);
        check("tim_ch1", samp[1], 201);
        check("tim_ch2", samp[2], 0);
        check("tim_ch3", samp[3], LUT0);

        // Strobe mid-frame plus a clear written mid-frame
        cfg_write(0, 24'h400000, 16'h8000, 1'b1, 1'b0);
        stb2_cycle = 5;
        wr_cycle   = 6;
        wr_ch = 4'd0; wr_inc = 24'h400000; wr_gain = 16'h8000; wr_en = 1'b1; wr_clr = 1'b1;
        run_frame();
        check("ovr_ch0", samp[0], LUT0);
        check("ovr_ch1", samp[1], 201);
        check("ovr_nvalid", longint'(nvalid), NCH);
        check("ovr_ndone", longint'(ndone), 1);
        check("ovr_flag", longint'(overrun), 1);
        check("ovr_no_restart", longint'(busy_log[FRAME_CYC + 1]), 0);
        run_frame();
        check("clr_ch0", samp[0], LUT0);
        check("ovr_sticky", longint'(overrun), 1);

        // Write in the strobe cycle lands in shadow only
        wr_cycle = 0;
        wr_ch = 4'd0; wr_inc = 24'h400000; wr_gain = 16'h0000; wr_en = 1'b1; wr_clr = 1'b0;
        run_frame();
        check("samecyc_old_gain", samp[0], LUT255);
        run_frame();
        check("samecyc_new_gain", samp[0], 0);

        // Strobe coinciding with frame_done
        do_reset();
        check("rst2_overrun", longint'(overrun), 0);
        cfg_write(0, 24'h400000, 16'h8000, 1'b1, 1'b0);
        stb2_cycle = FRAME_CYC;
        run_frame();
        check("fdstb_ch0", samp[0], LUT0);
        check("fdstb_ovr_before", longint'(ovr_log[FRAME_CYC]), 0);
        check("fdstb_ovr_after", longint'(ovr_log[FRAME_CYC + 1]), 1);
        check("fdstb_no_start", longint'(busy_log[FRAME_CYC + 1]), 0);

        // Reset during MUL of ch2
        cfg_write(1, 24'h400000, 16'h8000, 1'b1, 1'b0);
        cfg_write(2, 24'h400000, 16'h8000, 1'b1, 1'b0);
        rst_cycle = 11;
        run_frame();
        check("midrst_valid_before", longint'(valid_log[8]), 1);
        check("midrst_valid", longint'(valid_log[12]), 0);
        check("midrst_busy", longint'(busy_log[12]), 0);
        check("midrst_data", data_log[12], 0);
        check("midrst_ch", longint'(ch_log[12]), 0);
        check("midrst_overrun", longint'(ovr_log[12]), 0);
        check("midrst_nvalid", longint'(nvalid), 2);
        cfg_write(0, 24'h400000, 16'h8000, 1'b1, 1'b0);
        run_frame();
        check("after_rst_ch0", samp[0], LUT0);
        check("after_rst_first_ch", longint'(ch_log[4]), 0);
        check("after_rst_ch1_disabled", samp[1], 0);
        check("after_rst_nvalid", longint'(nvalid), NCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
